// File: rtl/frame_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_ctrl_pkg                                                           |
// | Shared state encoding and width helpers for frame_swap_ctrl and its      |
// | raster walker. Supplies default frame sizes when the build has none.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifndef H_FRAME_HT
`define H_FRAME_HT 640
`endif
`ifndef V_FRAME_HT
`define V_FRAME_HT 480
`endif

package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        RENDER = 2'd1,
        READY  = 2'd2
    } fsc_state_t;

    // Counter width for n positions; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raster_counter                                                           |
// | Row-major row/column walker for full-frame sweeps. Steps on advance_i,   |
// | flags the final pixel on last_o and wraps to (0,0) after it.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module raster_counter
    import frame_ctrl_pkg::*;
#(
    parameter int H_PIX = 4,
    parameter int V_PIX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    advance_i,
    output logic [cnt_w(V_PIX)-1:0] row_o,
    output logic [cnt_w(H_PIX)-1:0] col_o,
    output logic                    last_o
);

    localparam int c_ROW_W = cnt_w(V_PIX);
    localparam int c_COL_W = cnt_w(H_PIX);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(V_PIX - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(H_PIX - 1);

    logic [c_ROW_W-1:0] row_q, row_d;
    logic [c_COL_W-1:0] col_q, col_d;
    logic               w_col_wrap;

    assign w_col_wrap = (col_q == c_COL_LAST);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (advance_i) begin
            if (w_col_wrap) begin
                col_d = '0;
                row_d = (row_q == c_ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = w_col_wrap && (row_q == c_ROW_LAST);

endmodule

`default_nettype wire

// File: rtl/frame_swap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_swap_ctrl                                                          |
// | Double-buffer sequencer: clear back buffer, run renderer, swap on        |
// | vblank. Back-buffer clear is built only when FRAME_CLEAR_EN is defined.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifndef H_FRAME_HT
`define H_FRAME_HT 640
`endif
`ifndef V_FRAME_HT
`define V_FRAME_HT 480
`endif

module frame_swap_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int H_PIX  = `H_FRAME_HT,
    parameter int V_PIX  = `V_FRAME_HT,
    parameter int MISS_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    refresh,
    input  logic                    render_done,
    input  logic                    clr_ready,
    output logic                    front_sel,
    output logic                    render_go,
    output logic                    swap,
    output logic                    clr_we,
    output logic [cnt_w(V_PIX)-1:0] clr_row,
    output logic [cnt_w(H_PIX)-1:0] clr_col,
    output logic [MISS_W-1:0]       missed
);

    fsc_state_t        state_q;
    logic              front_sel_q;
    logic              render_go_q;
    logic              swap_q;
    logic              run_q;
    logic [MISS_W-1:0] missed_q;
    logic              w_clr_adv;
    logic              w_clr_last;
    logic              w_done_ok;

`ifdef FRAME_CLEAR_EN
    localparam fsc_state_t c_INIT_STATE = CLEAR;
    localparam logic       c_GO_ON_SWAP = 1'b0;

    logic w_clr_active;

    // run_q keeps clr_we low for the reset cycle without a path from rst.
    assign w_clr_active = (state_q == CLEAR) && run_q;
    assign w_clr_adv    = w_clr_active && clr_ready;
    assign clr_we       = w_clr_active;

    raster_counter #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .advance_i (w_clr_adv),
        .row_o     (clr_row),
        .col_o     (clr_col),
        .last_o    (w_clr_last)
    );
`else
    localparam fsc_state_t c_INIT_STATE = RENDER;
    localparam logic       c_GO_ON_SWAP = 1'b1;

    logic w_unused_clr_ready;

    assign w_unused_clr_ready = clr_ready;
    assign w_clr_adv          = 1'b0;
    assign w_clr_last         = 1'b0;
    assign clr_we             = 1'b0;
    assign clr_row            = '0;
    assign clr_col            = '0;
`endif

    // Completion is ignored until the renderer has seen its go pulse.
    assign w_done_ok = run_q && !render_go_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_INIT_STATE;
            front_sel_q <= 1'b0;
            render_go_q <= 1'b0;
            swap_q      <= 1'b0;
            run_q       <= 1'b0;
            missed_q    <= '0;
        end else begin
            run_q       <= 1'b1;
            render_go_q <= 1'b0;
            swap_q      <= 1'b0;
            if (refresh && (state_q != READY) && (missed_q != '1)) begin
                missed_q <= missed_q + 1'b1;
            end
            case (state_q)
                CLEAR: begin
                    if (w_clr_adv && w_clr_last) begin
                        state_q     <= RENDER;
                        render_go_q <= 1'b1;
                    end
                end
                RENDER: begin
                    if (!run_q) begin
                        render_go_q <= 1'b1;
                    end
                    if (render_done && w_done_ok) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (refresh) begin
                        front_sel_q <= !front_sel_q;
                        swap_q      <= 1'b1;
                        render_go_q <= c_GO_ON_SWAP;
                        state_q     <= c_INIT_STATE;
                    end
                end
                default: state_q <= c_INIT_STATE;
            endcase
        end
    end

    assign front_sel = front_sel_q;
    assign render_go = render_go_q;
    assign swap      = swap_q;
    assign missed    = missed_q;

endmodule

`default_nettype wire
